// File: rtl/secded_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : secded_pkg
//  Purpose  : Shared types for the 13-bit SECDED scrubber: codeword and
//             syndrome types and the scrubber state enumeration.
//  Revision : 1.0  initial release
// ============================================================================
package secded_pkg;

  localparam int CW_BITS = 13;

  typedef logic [CW_BITS-1:0] codeword_t;
  typedef logic [3:0]         syndrome_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    WRITE = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } scrub_state_t;

endpackage
`default_nettype wire

// File: rtl/secded_check.sv
`default_nettype none
// ============================================================================
//  Module   : secded_check
//  Purpose  : Combinational SECDED decoder. Hamming syndrome over positions
//             1..12, overall parity in bit 0. Flags correctable and
//             uncorrectable words and returns the corrected codeword.
//  Revision : 1.0  initial release
// ============================================================================
module secded_check
  import secded_pkg::*;
(
  input  codeword_t cw,
  output syndrome_t syndrome,
  output logic      single_err,
  output logic      double_err,
  output codeword_t corrected
);

  logic w_parity;

  // Syndrome bit n is the parity of every position whose index has bit n set.
  always_comb begin
    syndrome[0] = cw[1] ^ cw[3] ^ cw[5]  ^ cw[7]  ^ cw[9]  ^ cw[11];
    syndrome[1] = cw[2] ^ cw[3] ^ cw[6]  ^ cw[7]  ^ cw[10] ^ cw[11];
    syndrome[2] = cw[4] ^ cw[5] ^ cw[6]  ^ cw[7]  ^ cw[12];
    syndrome[3] = cw[8] ^ cw[9] ^ cw[10] ^ cw[11] ^ cw[12];
  end

  assign w_parity = ^cw;

  // Odd parity with a syndrome that names a real position (0 means bit 0
  // itself) is a single flip; anything else non-clean is uncorrectable.
  always_comb begin
    single_err = w_parity && (syndrome <= 4'd12);
    double_err = (!w_parity && (syndrome != 4'd0)) ||
                 (w_parity && (syndrome >= 4'd13));
    corrected  = cw ^ (single_err ? (codeword_t'(1) << syndrome) : '0);
  end

endmodule
`default_nettype wire

// File: rtl/secded_scrubber.sv
`default_nettype none
// ============================================================================
//  Module   : secded_scrubber
//  Purpose  : Background scrubber for 13-bit SECDED memory words. Walks
//             addresses 0..DEPTH-1, writes back single-bit corrections and
//             counts/logs uncorrectable words. The host always has priority
//             on the memory port.
//  Options  : SCRUB_AUTO_EN - start a pass automatically after INTERVAL
//             consecutive idle cycles.
//  Revision : 1.0  initial release
// ============================================================================
module secded_scrubber
  import secded_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int INTERVAL = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output codeword_t         mem_wdata,
  input  codeword_t         mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        cnt_1bit,
  output logic [7:0]        cnt_2bit,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  scrub_state_t      r_state;
  scrub_state_t      w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_err_addr;
  codeword_t         r_word;
  codeword_t         w_corrected;
  syndrome_t         w_syndrome;
  logic              w_single;
  logic              w_double;
  logic              r_cancel;
  logic              w_host_hit;
  logic              w_go;
  logic              w_auto;
  logic              r_busy;
  logic              r_done;
  logic              r_err_valid;
  logic [7:0]        r_cnt1;
  logic [7:0]        r_cnt2;
  logic              w_unused;

  secded_check u_check (
    .cw         (r_word),
    .syndrome   (w_syndrome),
    .single_err (w_single),
    .double_err (w_double),
    .corrected  (w_corrected)
  );

  // The raw syndrome is not needed here; the decoder already applies it.
  assign w_unused = ^w_syndrome;

  // A host write to the word being scrubbed makes our copy stale.
  assign w_host_hit = host_req & host_we & (host_addr == r_addr);

`ifdef SCRUB_AUTO_EN
  localparam int c_idle_w = $clog2(INTERVAL + 1);
  logic [c_idle_w-1:0] r_idle_cnt;

  // Count consecutive IDLE cycles; restart whenever a pass begins.
  always_ff @(posedge clock) begin
    if (reset || (r_state != IDLE) || w_go) r_idle_cnt <= '0;
    else                                    r_idle_cnt <= r_idle_cnt + c_idle_w'(1);
  end

  assign w_auto = (r_state == IDLE) && (r_idle_cnt == c_idle_w'(INTERVAL - 1));
`else
  assign w_auto = 1'b0;
`endif

  assign w_go = start | w_auto;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and the combinational memory strobes.
  always_comb begin
    w_next = r_state;
    mem_re = 1'b0;
    mem_we = 1'b0;
    case (r_state)
      IDLE:  if (w_go) w_next = READ;
      READ: begin
        mem_re = ~host_req;
        if (!host_req) w_next = WAIT;
      end
      WAIT:  w_next = CHECK;
      CHECK: w_next = w_single ? WRITE : NEXT;
      WRITE: begin
        mem_we = ~host_req & ~r_cancel;
        if (r_cancel || !host_req) w_next = NEXT;
      end
      NEXT:  w_next = (r_addr == c_last_addr) ? DONE : READ;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: word capture, correction, counters, error log, status flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_word      <= '0;
      r_cancel    <= 1'b0;
      r_cnt1      <= '0;
      r_cnt2      <= '0;
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_addr      <= '0;
            r_cnt1      <= '0;
            r_cnt2      <= '0;
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
          end
        end
        READ: r_cancel <= 1'b0;
        WAIT: begin
          r_word <= mem_rdata;
          if (w_host_hit) r_cancel <= 1'b1;
        end
        CHECK: begin
          r_word <= w_corrected;
          if (w_host_hit) r_cancel <= 1'b1;
          if (w_single && (r_cnt1 != 8'hFF)) r_cnt1 <= r_cnt1 + 8'd1;
          if (w_double) begin
            if (r_cnt2 != 8'hFF) r_cnt2 <= r_cnt2 + 8'd1;
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr;
          end
        end
        WRITE: if (w_host_hit) r_cancel <= 1'b1;
        NEXT:  if (r_addr != c_last_addr) r_addr <= r_addr + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_word;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cnt_1bit  = r_cnt1;
  assign cnt_2bit  = r_cnt2;
  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_secded_scrubber.sv
`default_nettype none
// ============================================================================
//  Module   : tb_secded_scrubber
//  Purpose  : Self-checking bench for secded_scrubber (DEPTH=4): directed
//             vector table, randomized passes against an encode-and-flip
//             reference, host-contention and reset corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_secded_scrubber;

  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int INTERVAL = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [12:0]       host_wdata = '0;
  logic              mem_re, mem_we, busy, done, err_valid;
  logic [ADDR_W-1:0] mem_addr, err_addr;
  logic [12:0]       mem_wdata;
  logic [12:0]       rdata_q;
  logic [7:0]        cnt_1bit, cnt_2bit;

  logic [12:0] mem [0:DEPTH-1];
  int cyc = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int checks = 0;
  int failures = 0;

  secded_scrubber #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INTERVAL(INTERVAL)) dut (
    .clock     (clk),
    .reset     (rst),
    .start     (start),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (rdata_q),
    .busy      (busy),
    .done      (done),
    .cnt_1bit  (cnt_1bit),
    .cnt_2bit  (cnt_2bit),
    .err_valid (err_valid),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  // Single-port memory model: one-cycle read latency, host and scrubber writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (host_req && host_we) mem[host_addr] <= host_wdata;
    if (mem_re) rdata_q <= mem[mem_addr];
  end

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  typedef struct {
    logic [3:0][12:0] init;
    int lat, c1, c2, ev, ea, we;
    logic [3:0][12:0] fin;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Build a valid codeword: data in non-power-of-two positions, Hamming
  // check bits at 1/2/4/8, overall even parity in bit 0.
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] cw;
    int k;
    cw = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        if (d[k[2:0]]) cw = cw | (13'(1) << p);
        k++;
      end
    end
    for (int c = 1; c <= 8; c = c * 2) begin
      logic par;
      par = 1'b0;
      for (int j = 1; j <= 12; j++)
        if (j != c && (j & c) != 0) par = par ^ cw[j[3:0]];
      if (par) cw = cw | (13'(1) << c);
    end
    if (^cw[12:1]) cw = cw | 13'd1;
    return cw;
  endfunction

  task automatic load(input logic [3:0][12:0] w);
    for (int i = 0; i < DEPTH; i++) begin
      host_req   = 1'b1;
      host_we    = 1'b1;
      host_addr  = ADDR_W'(i);
      host_wdata = w[i];
      tick();
    end
    host_req = 1'b0;
    host_we  = 1'b0;
  endtask

  task automatic do_pass(input string tag, input logic [3:0][12:0] init,
                         input int lat, input int c1, input int c2,
                         input int ev, input int ea, input int we,
                         input logic [3:0][12:0] fin);
    int re0, we0, e, dc;
    bit seen;
    load(init);
    re0 = re_cnt;
    we0 = we_cnt;
    start = 1'b1;
    e = cyc + 1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    dc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dc = cyc;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s done_timeout actual=none required=done", tag);
    end else begin
      check({tag, " latency"}, dc - e, lat);
    end
    check({tag, " cnt_1bit"}, int'(cnt_1bit), c1);
    check({tag, " cnt_2bit"}, int'(cnt_2bit), c2);
    check({tag, " err_valid"}, int'(err_valid), ev);
    check({tag, " err_addr"}, int'(err_addr), ea);
    tick();
    check({tag, " busy_after"}, int'(busy), 0);
    check({tag, " re_count"}, re_cnt - re0, DEPTH);
    check({tag, " we_count"}, we_cnt - we0, we);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s mem[%0d]", tag, i), int'(mem[i]), int'(fin[i]));
  endtask

  initial begin
    int m, first, e, re0, we0, dc;
    int c1, c2, ev, ea, nf, pos1, pos2;
    bit seen;
    logic [12:0] good, bad;
    logic [3:0][12:0] init, fin;

    tick(); tick(); tick();
    @(negedge clk);
    check("reset mem_re", int'(mem_re), 0);
    check("reset mem_we", int'(mem_we), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset mem_wdata", int'(mem_wdata), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset cnt_1bit", int'(cnt_1bit), 0);
    check("reset cnt_2bit", int'(cnt_2bit), 0);
    check("reset err_valid", int'(err_valid), 0);
    check("reset err_addr", int'(err_addr), 0);
    tick();
    rst = 1'b0;
    m = cyc;

`ifdef SCRUB_AUTO_EN
    first = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (mem_re && first < 0) first = cyc;
    end
    check("auto start delay", first - m, INTERVAL);
`else
    // Directed vectors: {w3,w2,w1,w0}.
    tbl[0] = '{init: {13'h0, 13'h0, 13'h0, 13'h0}, lat: 16, c1: 0, c2: 0, ev: 0, ea: 0, we: 0,
               fin:  {13'h0, 13'h0, 13'h0, 13'h0}};
    tbl[1] = '{init: {13'h0, 13'h0020, 13'h0, 13'h0}, lat: 17, c1: 1, c2: 0, ev: 0, ea: 0, we: 1,
               fin:  {13'h0, 13'h0, 13'h0, 13'h0}};
    tbl[2] = '{init: {13'h0, 13'h0, 13'h0001, 13'h0}, lat: 17, c1: 1, c2: 0, ev: 0, ea: 0, we: 1,
               fin:  {13'h0, 13'h0, 13'h0, 13'h0}};
    tbl[3] = '{init: {13'h0028, 13'h0, 13'h0, 13'h0}, lat: 16, c1: 0, c2: 1, ev: 1, ea: 3, we: 0,
               fin:  {13'h0028, 13'h0, 13'h0, 13'h0}};
    tbl[4] = '{init: {13'h0, 13'h1003, 13'h1000, 13'h0006}, lat: 17, c1: 1, c2: 2, ev: 1, ea: 2, we: 1,
               fin:  {13'h0, 13'h1003, 13'h0, 13'h0006}};
    for (int v = 0; v < 5; v++)
      do_pass($sformatf("vec%0d", v), tbl[v].init, tbl[v].lat, tbl[v].c1, tbl[v].c2,
              tbl[v].ev, tbl[v].ea, tbl[v].we, tbl[v].fin);

    // Randomized passes: valid codewords with 0, 1 or 2 injected flips.
    for (int p = 0; p < 8; p++) begin
      c1 = 0; c2 = 0; ev = 0; ea = 0;
      for (int w = 0; w < DEPTH; w++) begin
        good = encode(8'($urandom_range(0, 255)));
        nf   = $urandom_range(0, 2);
        pos1 = $urandom_range(0, 12);
        pos2 = (pos1 + $urandom_range(1, 12)) % 13;
        bad  = good;
        if (nf >= 1) bad = bad ^ (13'(1) << pos1);
        if (nf == 2) bad = bad ^ (13'(1) << pos2);
        init[w] = bad;
        fin[w]  = (nf == 2) ? bad : good;
        if (nf == 1) c1++;
        if (nf == 2) begin c2++; ev = 1; ea = w; end
      end
      do_pass($sformatf("rand%0d", p), init, 16 + c1, c1, c2, ev, ea, c1, fin);
    end

    // Host holds the port for 3 cycles in READ, then overwrites the word
    // under correction while it is in CHECK: the write-back must be dropped.
    load({13'h0, 13'h0, 13'h0, 13'h0020});
    re0 = re_cnt;
    we0 = we_cnt;
    start = 1'b1;
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 2'd2;
    e = cyc + 1;
    tick();                  // E: READ
    start = 1'b0;
    tick();                  // E+1
    tick();                  // E+2
    tick();                  // E+3
    host_req = 1'b0;
    @(negedge clk);
    check("hostA mem_re_after_hold", int'(mem_re), 1);
    tick();                  // E+4: WAIT
    tick();                  // E+5: CHECK
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 2'd0;
    host_wdata = 13'h0155;
    tick();                  // E+6: WRITE, cancelled
    host_req = 1'b0;
    host_we = 1'b0;
    @(negedge clk);
    check("hostA mem_we_cancelled", int'(mem_we), 0);
    seen = 1'b0;
    dc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; dc = cyc; break; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL hostA done_timeout actual=none required=done");
    end else begin
      check("hostA latency", dc - e, 20);
    end
    check("hostA cnt_1bit", int'(cnt_1bit), 1);
    tick();
    check("hostA we_count", we_cnt - we0, 0);
    check("hostA re_count", re_cnt - re0, DEPTH);
    check("hostA mem0_host_value", int'(mem[0]), 13'h0155);

    // Reset asserted while in WRITE.
    load({13'h0, 13'h0, 13'h0, 13'h0020});
    start = 1'b1;
    tick();                  // E: READ
    start = 1'b0;
    tick();                  // E+1: WAIT
    tick();                  // E+2: CHECK
    tick();                  // E+3: WRITE
    rst = 1'b1;
    @(negedge clk);
    check("rstW mem_we_in_write", int'(mem_we), 1);
    check("rstW cnt_1bit_in_write", int'(cnt_1bit), 1);
    tick();                  // E+4: back in IDLE
    @(negedge clk);
    check("rstW mem_we_after", int'(mem_we), 0);
    check("rstW busy_after", int'(busy), 0);
    check("rstW cnt_1bit_after", int'(cnt_1bit), 0);
    check("rstW mem_addr_after", int'(mem_addr), 0);
    rst = 1'b0;
    tick();
    re0 = re_cnt;
    we0 = we_cnt;
    for (int t = 0; t < 12; t++) tick();
    check("rstW no_re", re_cnt - re0, 0);
    check("rstW no_we", we_cnt - we0, 0);
    check("rstW idle", int'(busy), 0);
    check("rstW mem0", int'(mem[0]), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/secded_scrubber.md
# secded_scrubber

Background memory scrubber for the 13-bit SECDED code: 8 data bits, Hamming check bits at positions 1/2/4/8, overall parity at bit 0. It walks a single-port memory one word at a time and passes each word through a SECDED check. Single-bit errors are written back corrected, and double-bit errors are counted and logged. The block sits between the host and the memory port, and the host always takes priority.

## Interface
- DEPTH, 16: number of words scrubbed per pass, addresses 0..DEPTH-1.
- ADDR_W, $clog2(DEPTH): address width.
- INTERVAL, 1024: idle cycles between automatic passes. Used only with SCRUB_AUTO_EN.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a scrub pass. Honoured only in IDLE.
- host_req  in  1  host owns the memory port this cycle.
- host_we  in  1  host is writing this cycle, qualified by host_req.
- host_addr  in  ADDR_W  host address.
- mem_re  out  1  scrubber read strobe.
- mem_we  out  1  scrubber write strobe.
- mem_addr  out  ADDR_W  scrub address.
- mem_wdata  out  13  corrected codeword.
- mem_rdata  in  13  read data, valid the cycle after mem_re.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- cnt_1bit  out  8  corrected errors this pass, saturates at 255.
- cnt_2bit  out  8  uncorrectable errors this pass, saturates at 255.
- err_valid  out  1  sticky: an uncorrectable word was seen this pass.
- err_addr  out  ADDR_W  address of the most recent uncorrectable word.

## Operation
- States: IDLE, READ, WAIT, CHECK, WRITE, NEXT, DONE.
- IDLE, start=1: clear counters, err_valid, err_addr; addr←0; go to READ.
- READ: mem_re = ~host_req. If host_req, hold in READ; else go to WAIT.
- WAIT: capture mem_rdata into word register; go to CHECK.
- CHECK, syndrome s from positions 1..12, p = XOR of all 13 bits:
  - p=0, s=0: clean; go to NEXT.
  - p=1, 1≤s≤12: flip bit s; cnt_1bit++; go to WRITE.
  - p=1, s=0: flip bit 0; cnt_1bit++; go to WRITE.
  - p=0, s≠0: cnt_2bit++; err_valid←1; err_addr←addr; go to NEXT.
  - p=1, s≥13: uncorrectable; handle as p=0, s≠0.
- WRITE: mem_we = ~host_req, mem_wdata = corrected word. Hold in WRITE while host_req; else go to NEXT.
- Stale-data guard: a host write (host_req & host_we) with host_addr==addr, seen in WAIT, CHECK or WRITE, sets a cancel flag. WRITE with the flag set issues no mem_we and goes straight to NEXT; cnt_1bit still counts the error.
- NEXT: if addr==DEPTH-1 go to DONE; else addr++ and go to READ.
- DONE: done=1; go to IDLE.
- start while busy is ignored; it is not queued.
- Counters and err_* hold their values in IDLE until the next accepted start.

## Timing
- Reset values: state IDLE; all outputs 0; mem_addr 0.
- mem_re and mem_we are combinational from state and host_req. All other outputs are registered.
- Clean word: 4 cycles. Corrected word: 5 cycles. Each host_req cycle in READ or WRITE adds 1 cycle.
- start sampled at edge k, no host traffic, all words clean: mem_re in cycle k+1; done high in cycle k+1+4·DEPTH.
- Reset asserted mid-pass: IDLE on the next edge; no further mem_re or mem_we; the partial pass is discarded.

## Configuration
- SCRUB_AUTO_EN defined: an idle counter runs in IDLE. After INTERVAL consecutive IDLE cycles the block starts a pass as if start=1. The counter clears on any pass start.
- SCRUB_AUTO_EN undefined: passes begin only on start. No interval counter is synthesised.

## Structure
- Package secded_pkg holds:
  - codeword_t: logic [12:0]
  - syndrome_t: logic [3:0]
  - enum scrub_state_t
  - CW_BITS=13
- Sub-module secded_check: combinational. Input codeword_t. Outputs syndrome, single_err, double_err, corrected codeword_t. The FSM and counters live in secded_scrubber.

## Test plan
- DEPTH=4, all words 13'h0000, start pulse: four mem_re, no mem_we, done at k+17, both counters 0.
- Word 2 = 13'h0020 (bit 5 flipped): s=5, p=1; mem_we to addr 2 with 13'h0000; cnt_1bit=1.
- Word 1 = 13'h0001 (bit 0 flipped): s=0, p=1; write back 13'h0000; cnt_1bit=1.
- Word 3 = 13'h0028 (bits 3 and 5 flipped): s=6, p=0; no mem_we; cnt_2bit=1, err_valid=1, err_addr=3.
- host_req held 3 cycles during READ, then a host write to the scrub address during CHECK of a corrupted word: READ extends 3 cycles; no mem_we for that word; cnt_1bit=1.
- reset asserted in WRITE: mem_we=0 in the next cycle, state IDLE, counters 0. With SCRUB_AUTO_EN and INTERVAL=8: a pass begins after 8 IDLE cycles.
